// File: rtl/risc_v_mike_lsu.sv
// Load/store unit: one request/grant/rvalid transaction per accepted op, with lane
// steering of byte enables and store data, and sign/zero extension of load data.
module risc_v_mike_lsu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [1:0]          lane_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [3:0]          mem_be_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [4:0]          rsp_rd_q;
    logic                rsp_err_q;
    logic                accept;
    logic                req_ok;

    // Size comes from funct3[1:0]; funct3[2] marks unsigned loads and is illegal on stores.
    function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic legal;
        if (we) legal = !f3[2] && (f3[1:0] != 2'b11);
        else    legal = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
        case (f3[1:0])
            2'b01:   return legal && !a[0];
            2'b10:   return legal && (a == 2'b00);
            default: return legal;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_data(input logic [1:0] size, input logic [DATA_W-1:0] w);
        case (size)
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                                  input logic [DATA_W-1:0] rdata);
        logic [DATA_W-1:0] sh;
        sh = rdata >> {a, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign accept = (state_q == IDLE) && req_valid;
    assign req_ok = access_ok(req_we, req_funct3, req_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid)  state_d = req_ok ? REQ : RESP;
            REQ:  if (mem_gnt)    state_d = we_q ? RESP : WAIT;
            WAIT: if (mem_rvalid) state_d = RESP;
            RESP:                 state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        mem_req   = (state_q == REQ);
        mem_we    = (state_q == REQ) && we_q;
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
    end

    // Memory-side fields only move on a legal accept, so rejected ops never disturb the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= 5'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                rsp_data_q <= '0;
                rsp_rd_q   <= req_rd;
                rsp_err_q  <= !req_ok;
                if (req_ok) begin
                    we_q        <= req_we;
                    funct3_q    <= req_funct3;
                    lane_q      <= req_addr[1:0];
                    mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                    mem_be_q    <= byte_en(req_funct3[1:0], req_addr[1:0]);
                    mem_wdata_q <= store_data(req_funct3[1:0], req_wdata);
                end
            end
            if ((state_q == WAIT) && mem_rvalid)
                rsp_data_q <= load_ext(funct3_q, lane_q, mem_rdata);
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_risc_v_mike_lsu.sv
// Directed bench for risc_v_mike_lsu: drives ops and the memory handshake by hand and
// compares every response against hand-computed values.
module tb_risc_v_mike_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    risc_v_mike_lsu #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [4:0] rd, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_data);
        issue(1'b0, f3, addr, 32'h0, rd);
        check_eq({tag, "_req"},  32'(mem_req), 1);
        check_eq({tag, "_addr"}, mem_addr, exp_addr);
        check_eq({tag, "_be"},   32'(mem_be), 32'(exp_be));
        check_eq({tag, "_we"},   32'(mem_we), 0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_eq({tag, "_reqdrop"}, 32'(mem_req), 0);
        check_eq({tag, "_early"},   32'(rsp_valid), 0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
        check_eq({tag, "_vld"},  32'(rsp_valid), 1);
        check_eq({tag, "_data"}, rsp_data, exp_data);
        check_eq({tag, "_rd"},   32'(rsp_rd), 32'(rd));
        check_eq({tag, "_err"},  32'(rsp_err), 0);
        tick();
        check_eq({tag, "_pulse"}, 32'(rsp_valid), 0);
        check_eq({tag, "_ready"}, 32'(req_ready), 1);
    endtask

    task automatic run_err(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [4:0] rd);
        issue(we, f3, addr, 32'hFFFF_FFFF, rd);
        check_eq({tag, "_noreq"}, 32'(mem_req), 0);
        check_eq({tag, "_vld"},   32'(rsp_valid), 1);
        check_eq({tag, "_err"},   32'(rsp_err), 1);
        check_eq({tag, "_data"},  rsp_data, 0);
        check_eq({tag, "_rd"},    32'(rsp_rd), 32'(rd));
        tick();
        check_eq({tag, "_pulse"}, 32'(rsp_valid), 0);
        check_eq({tag, "_noreq2"}, 32'(mem_req), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, 32'(req_ready), 1);
        check_eq({tag, "_req"},   32'(mem_req), 0);
        check_eq({tag, "_we"},    32'(mem_we), 0);
        check_eq({tag, "_be"},    32'(mem_be), 0);
        check_eq({tag, "_addr"},  mem_addr, 0);
        check_eq({tag, "_wdata"}, mem_wdata, 0);
        check_eq({tag, "_vld"},   32'(rsp_valid), 0);
        check_eq({tag, "_err"},   32'(rsp_err), 0);
        check_eq({tag, "_data"},  rsp_data, 0);
        check_eq({tag, "_rd"},    32'(rsp_rd), 0);
        check_eq({tag, "_busy"},  32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        tick(); tick();
        rst = 1'b0;
        check_reset_vals("rst");

        // Stray rvalid while idle
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        check_eq("idle_rvalid_vld", 32'(rsp_valid), 0);
        check_eq("idle_rvalid_busy", 32'(busy), 0);

        run_load("lw",  3'b010, 32'h0000_0100, 5'd5,  32'hDEAD_BEEF, 32'h100, 4'b1111, 32'hDEAD_BEEF);
        run_load("lb",  3'b000, 32'h0000_0103, 5'd6,  32'h80FF_0000, 32'h100, 4'b1000, 32'hFFFF_FF80);
        run_load("lbu", 3'b100, 32'h0000_0103, 5'd7,  32'h80FF_0000, 32'h100, 4'b1000, 32'h0000_0080);
        run_load("lh",  3'b001, 32'h0000_0102, 5'd8,  32'h80FF_0000, 32'h100, 4'b1100, 32'hFFFF_80FF);
        run_load("lhu", 3'b101, 32'h0000_0102, 5'd9,  32'h80FF_0000, 32'h100, 4'b1100, 32'h0000_80FF);
        run_load("lb0", 3'b000, 32'h0000_0200, 5'd10, 32'h0000_007F, 32'h200, 4'b0001, 32'h0000_007F);

        // SB with grant held off for three cycles
        issue(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 5'd11);
        for (int i = 0; i < 3; i++) begin
            check_eq("sb_hold_req",   32'(mem_req), 1);
            check_eq("sb_hold_addr",  mem_addr, 32'h200);
            check_eq("sb_hold_be",    32'(mem_be), 32'b0010);
            check_eq("sb_hold_wdata", mem_wdata, 32'hABAB_ABAB);
            check_eq("sb_hold_we",    32'(mem_we), 1);
            tick();
        end
        check_eq("sb_gnt_req", 32'(mem_req), 1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_eq("sb_vld",   32'(rsp_valid), 1);
        check_eq("sb_data",  rsp_data, 0);
        check_eq("sb_rd",    32'(rsp_rd), 11);
        check_eq("sb_err",   32'(rsp_err), 0);
        check_eq("sb_reqoff", 32'(mem_req), 0);
        tick();
        check_eq("sb_pulse", 32'(rsp_valid), 0);

        // SH, zero-wait grant
        issue(1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd12);
        check_eq("sh_be",    32'(mem_be), 32'b1100);
        check_eq("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_eq("sh_vld", 32'(rsp_valid), 1);
        tick();

        run_err("lw_mis",  1'b0, 3'b010, 32'h0000_0102, 5'd13);
        run_err("sh_mis",  1'b1, 3'b001, 32'h0000_0103, 5'd14);
        run_err("ld_f011", 1'b0, 3'b011, 32'h0000_0100, 5'd15);
        run_err("st_f100", 1'b1, 3'b100, 32'h0000_0100, 5'd16);

        // Reset while waiting for load data, then a spurious rvalid
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd17);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_eq("wait_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("midrst");
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_rvalid = 1'b0;
        check_eq("midrst_spur_vld", 32'(rsp_valid), 0);
        check_eq("midrst_spur_rdy", 32'(req_ready), 1);
        check_eq("midrst_spur_data", rsp_data, 0);

        // Back-to-back with req_valid held; stray rvalid in REQ ignored
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0000_0300; req_wdata = 32'h0; req_rd = 5'd7;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        check_eq("b2b_req_hold", 32'(mem_req), 1);
        check_eq("b2b_no_vld",   32'(rsp_valid), 0);
        check_eq("b2b_not_rdy",  32'(req_ready), 0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_eq("b2b_gnt_rv_vld", 32'(rsp_valid), 0);
        check_eq("b2b_wait_busy",  32'(busy), 1);
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        check_eq("b2b1_vld",  32'(rsp_valid), 1);
        check_eq("b2b1_data", rsp_data, 32'hCAFE_F00D);
        check_eq("b2b1_rdy",  32'(req_ready), 0);
        req_we = 1'b1; req_addr = 32'h0000_0304; req_wdata = 32'h55AA_55AA; req_rd = 5'd9;
        tick();
        check_eq("b2b_idle_vld", 32'(rsp_valid), 0);
        check_eq("b2b_idle_rdy", 32'(req_ready), 1);
        check_eq("b2b_idle_req", 32'(mem_req), 0);
        tick();
        req_valid = 1'b0;
        check_eq("b2b2_req",   32'(mem_req), 1);
        check_eq("b2b2_addr",  mem_addr, 32'h304);
        check_eq("b2b2_we",    32'(mem_we), 1);
        check_eq("b2b2_wdata", mem_wdata, 32'h55AA_55AA);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_eq("b2b2_vld", 32'(rsp_valid), 1);
        check_eq("b2b2_rd",  32'(rsp_rd), 9);
        tick();
        check_eq("b2b2_done", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
